// File: rtl/rr_slot_arbiter_pkg.sv
// Shared definitions for the round-robin slot arbiter: FSM state encoding
// and an elaboration-time log2 helper.
package rr_slot_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Ceiling log2, floored at 1 so an index port is never zero-width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_slot_arbiter_pick.sv
// Combinational round-robin pick: the first set request at or above the one-hot
// priority pointer, wrapping to bit 0, returned as a one-hot vector.
module rr_pick
    import rr_slot_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] winner
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] diff_dbl;
    logic [2*N-1:0] win_dbl;

    // Subtracting the pointer from the doubled request vector borrows through
    // the bits below ptr; the lowest surviving set bit is the winner, and the
    // upper copy handles the wrap-around case.
    always_comb begin
        req_dbl  = {req, req};
        diff_dbl = req_dbl - {{N{1'b0}}, ptr};
        win_dbl  = req_dbl & ~diff_dbl;
        winner   = win_dbl[N-1:0] | win_dbl[2*N-1:N];
    end

endmodule

// File: rtl/rr_slot_arbiter.sv
// Round-robin time-slot arbiter: one owner at a time, each slot bounded to
// MAX_SLOT cycles, with a one-cycle gap between owners.
module rr_slot_arbiter
    import rr_slot_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_SLOT = 8,
    parameter int SLOT_W   = 4,
    parameter int ID_W     = clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      grant,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic              timeout
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_SLOT - 1);
    localparam logic [N-1:0]      PTR_RESET = N'(1);

    arb_state_e        state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [N-1:0]      ptr_q, ptr_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic              timeout_q, timeout_d;

    logic [N-1:0]      winner;
    logic              owner_req;
    logic              slot_last;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner)
    );

    assign owner_req = |(req & grant_q);
    assign slot_last = (slot_cnt_q == SLOT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= PTR_RESET;
            slot_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            slot_cnt_q <= slot_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // timeout defaults low so it is a single-cycle pulse even while frozen.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        slot_cnt_d = slot_cnt_q;
        timeout_d  = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (|req) begin
                        grant_d    = winner;
                        slot_cnt_d = '0;
                        state_d    = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Release is checked first so a release on the last slot
                    // cycle ends the slot without a timeout pulse.
                    if (!owner_req || slot_last) begin
                        grant_d    = '0;
                        ptr_d      = {grant_q[N-2:0], grant_q[N-1]};
                        slot_cnt_d = '0;
                        state_d    = ST_GAP;
                        timeout_d  = owner_req;
                    end else begin
                        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                    end
                end
                default: begin
                    grant_d    = '0;
                    slot_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == ST_BUSY);
    assign slot_cnt = slot_cnt_q;
    assign timeout  = timeout_q;

endmodule
